axi_ram_loader: RTL
===================

Name: axi_ram_loader

Overview:
- AXI4 write initiator that preloads the 64-bit on-chip RAM from a byte stream before the core runs, e.g. a flash or UART boot image.
- Packs bytes little-endian into 64-bit beats, buffers one burst, issues INCR bursts upward from BASE_ADDR, and finally reports done/error.
- o_init_done and o_init_error drive the core's i_ram_init_done and i_ram_init_error inputs.
- The block arbitrates the RAM write channels with the core during boot; AR/R are not part of this block.

Parameters:
- ID_WIDTH, 6, width of awid/bid.
- BASE_ADDR, 32'h0, first write byte address; must be aligned to BURST_LEN*8.
- MEM_SIZE, 32'h10000, bytes of RAM; a byte beyond this is an overflow.
- BURST_LEN, 8, beats per full burst; power of 2, 1..16.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active high
- i_data  in  8  stream byte
- i_valid  in  1  byte valid
- i_last  in  1  final byte of image, qualified by i_valid
- o_ready  out  1  byte accepted when i_valid&o_ready
- o_awid  out  ID_WIDTH  constant 0
- o_awaddr  out  32  burst start address
- o_awlen  out  8  beats-1
- o_awsize  out  3  constant 3 (8 bytes)
- o_awburst  out  2  constant 2'b01 INCR
- o_awvalid  out  1
- i_awready  in  1
- o_wdata  out  64
- o_wstrb  out  8
- o_wlast  out  1
- o_wvalid  out  1
- i_wready  in  1
- i_bid  in  ID_WIDTH  ignored
- i_bresp  in  2
- i_bvalid  in  1
- o_bready  out  1
- o_init_done  out  1  sticky, image fully written or error
- o_init_error  out  1  sticky, slave error or overflow

Behaviour:
- Reset values: o_ready=0, o_awvalid=0, o_wvalid=0, o_wlast=0, o_bready=0, o_awaddr=BASE_ADDR, o_awlen=0, o_wdata=0, o_wstrb=0, o_init_done=0, o_init_error=0. Internally: state FILL, byte ptr 0, beat ptr 0, buffer strobes 0.
- States: FILL, AW, W, B, DONE.
- FILL:
  - o_ready=1.
  - Each accepted byte goes to lane k=byte ptr: data[8k+7:8k], strobe bit k set.
  - Beat closes on the 8th byte or on i_last. Beat ptr increments and byte ptr clears.
  - Go to AW when BURST_LEN beats are buffered, or when the beat closed on i_last.
  - o_ready drops the cycle after the burst closes, so there is no byte acceptance in AW/W/B.
- AW:
  - o_awvalid=1; o_awaddr = BASE_ADDR + 8*(beats already written); o_awlen = buffered beats-1.
  - Address, length and valid are held stable until i_awready.
  - Go to W on the handshake.
- W:
  - Beats are presented in order from the buffer. o_wstrb is the per-beat strobe, partial only on the final beat of the image.
  - o_wlast=1 on beat o_awlen.
  - Advance on i_wready&o_wvalid. Go to B after the last-beat handshake.
  - W never starts before the AW handshake, and a burst never crosses 4 KB (guaranteed by alignment).
- B:
  - o_bready=1.
  - On i_bvalid with i_bresp!=0: set error, go to DONE.
  - Otherwise clear the buffer, then go to DONE if the image ended, else to FILL.
- DONE:
  - o_init_done=1 and all valids/ready stay 0 until reset. Further stream bytes stall.
- Overflow: an accepted byte whose address is >= BASE_ADDR+MEM_SIZE is dropped.
  - If any beats are buffered, flush them first: go to AW, then after B go to DONE with error.
  - If none are buffered, go directly to DONE with error.
- Simultaneous i_last and the BURST_LEN-th beat close: one burst, then DONE.
- Reset mid-burst: all state aborts immediately and asynchronously, and the outputs take their reset values. The slave is reset by the same reset.
- Counters: beat counter is 32-bit; address arithmetic is modulo 2^32; byte ptr is 3 bits, wrapping at 8.

Decomposition:
- Package axi_ram_loader_pkg: state enum (FILL, AW, W, B, DONE), AXI constants (BURST_INCR=2'b01, SIZE_8B=3'd3, RESP_OKAY=2'b00).
- One sub-module: axi_ram_loader_pack, the byte-to-64-bit packer with strobe and beat-close output, feeding the burst buffer in the top.

Test Plan:
- 16 bytes 0x00..0x0F, i_last on 0x0F; slave always ready → one AW addr 0x0 len 1; wdata 0x0706050403020100 then 0x0F0E0D0C0B0A0908, wstrb 0xFF, wlast on beat 1; done=1, error=0.
- 67 bytes, BURST_LEN=8 → AW 0x00 len 7, then AW 0x40 len 0 with wstrb 0x07; done=1.
- awready delayed 5 cycles and wready toggled every other cycle → awaddr/awlen/wdata held stable while not accepted; no byte accepted outside FILL; memory readback equals the image.
- Slave returns bresp=2'b10 on the first burst → o_init_error=1, o_init_done=1; no further AW; o_ready stays 0.
- MEM_SIZE=32, 40-byte image → bursts cover 32 bytes only; the 33rd byte is dropped; error=1, done=1.
- Reset asserted during W beat 3 → outputs at reset values the same cycle; after release, a new 8-byte image is written at BASE_ADDR.

Source files
------------

// File: rtl/axi_ram_loader_pkg.sv
// rtl/axi_ram_loader_pkg.sv - shared state encoding and AXI constants for the RAM loader
package axi_ram_loader_pkg;

  typedef enum logic [2:0] {
    ST_FILL,
    ST_AW,
    ST_W,
    ST_B,
    ST_DONE
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_8B    = 3'd3;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage

// File: rtl/axi_ram_loader_pack.sv
// rtl/axi_ram_loader_pack.sv - packs stream bytes little-endian into 64-bit beats with strobes
module axi_ram_loader_pack (
  input  logic        clk,
  input  logic        rst,
  input  logic        accept,
  input  logic [7:0]  byte_data,
  input  logic        last,
  output logic [63:0] beat_data,
  output logic [7:0]  beat_strb,
  output logic        beat_close,
  output logic [2:0]  byte_ptr
);

  logic [63:0] part_data;
  logic [7:0]  part_strb;

  // The closing beat includes the byte arriving this cycle, so the buffer sees it directly.
  always_comb begin
    beat_data = part_data;
    beat_strb = part_strb;
    beat_data[{byte_ptr, 3'b000} +: 8] = byte_data;
    beat_strb[byte_ptr] = 1'b1;
    beat_close = accept && ((byte_ptr == 3'd7) || last);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      part_data <= '0;
      part_strb <= '0;
      byte_ptr  <= '0;
    end else if (accept) begin
      if (beat_close) begin
        part_data <= '0;
        part_strb <= '0;
        byte_ptr  <= '0;
      end else begin
        part_data <= beat_data;
        part_strb <= beat_strb;
        byte_ptr  <= byte_ptr + 3'd1;
      end
    end
  end

endmodule

// File: rtl/axi_ram_loader.sv
// rtl/axi_ram_loader.sv - AXI4 write initiator preloading RAM from a byte stream in INCR bursts
module axi_ram_loader
  import axi_ram_loader_pkg::*;
#(
  parameter int          ID_WIDTH  = 6,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter logic [31:0] MEM_SIZE  = 32'h10000,
  parameter int          BURST_LEN = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          i_data,
  input  logic                i_valid,
  input  logic                i_last,
  output logic                o_ready,
  output logic [ID_WIDTH-1:0] o_awid,
  output logic [31:0]         o_awaddr,
  output logic [7:0]          o_awlen,
  output logic [2:0]          o_awsize,
  output logic [1:0]          o_awburst,
  output logic                o_awvalid,
  input  logic                i_awready,
  output logic [63:0]         o_wdata,
  output logic [7:0]          o_wstrb,
  output logic                o_wlast,
  output logic                o_wvalid,
  input  logic                i_wready,
  input  logic [ID_WIDTH-1:0] i_bid,
  input  logic [1:0]          i_bresp,
  input  logic                i_bvalid,
  output logic                o_bready,
  output logic                o_init_done,
  output logic                o_init_error
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam int IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

  state_t           state;
  logic [CNT_W-1:0] beat_cnt;
  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_next;
  logic [IDX_W-1:0] wr_idx;
  logic [31:0]      beats_written;
  logic [31:0]      byte_off;
  logic [31:0]      burst_addr;
  logic             image_end;
  logic             overflow;
  logic             byte_hs;
  logic             byte_ovf;
  logic             pack_accept;
  logic [63:0]      beat_data;
  logic [7:0]       beat_strb;
  logic             beat_close;
  logic [2:0]       byte_ptr;
  logic             unused_bid;

  logic [63:0] buf_data [BURST_LEN];
  logic [7:0]  buf_strb [BURST_LEN];

  assign o_awid     = '0;
  assign o_awsize   = SIZE_8B;
  assign o_awburst  = BURST_INCR;
  assign unused_bid = ^i_bid;

  // Overflow is judged on the offset from BASE_ADDR so a RAM at the top of the map still works.
  assign byte_off    = ((beats_written + 32'(beat_cnt)) << 3) + 32'(byte_ptr);
  assign byte_ovf    = (byte_off >= MEM_SIZE);
  assign byte_hs     = i_valid && o_ready && (state == ST_FILL);
  assign pack_accept = byte_hs && !byte_ovf;
  assign burst_addr  = BASE_ADDR + (beats_written << 3);
  assign wr_idx      = beat_cnt[IDX_W-1:0];
  assign w_next      = w_idx + 1'b1;

  axi_ram_loader_pack u_pack (
    .clk        (clk),
    .rst        (rst),
    .accept     (pack_accept),
    .byte_data  (i_data),
    .last       (i_last),
    .beat_data  (beat_data),
    .beat_strb  (beat_strb),
    .beat_close (beat_close),
    .byte_ptr   (byte_ptr)
  );

  always_ff @(posedge clk) begin
    if (beat_close) begin
      buf_data[wr_idx] <= beat_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BURST_LEN; i++) begin
        buf_strb[i] <= '0;
      end
    end else if ((state == ST_B) && i_bvalid) begin
      for (int i = 0; i < BURST_LEN; i++) begin
        buf_strb[i] <= '0;
      end
    end else if (beat_close) begin
      buf_strb[wr_idx] <= beat_strb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_FILL;
      beat_cnt      <= '0;
      w_idx         <= '0;
      beats_written <= '0;
      image_end     <= 1'b0;
      overflow      <= 1'b0;
      o_ready       <= 1'b0;
      o_awvalid     <= 1'b0;
      o_awaddr      <= BASE_ADDR;
      o_awlen       <= '0;
      o_wvalid      <= 1'b0;
      o_wdata       <= '0;
      o_wstrb       <= '0;
      o_wlast       <= 1'b0;
      o_bready      <= 1'b0;
      o_init_done   <= 1'b0;
      o_init_error  <= 1'b0;
    end else begin
      case (state)
        ST_FILL: begin
          o_ready <= 1'b1;
          if (byte_hs) begin
            if (byte_ovf) begin
              overflow <= 1'b1;
              o_ready  <= 1'b0;
              if (beat_cnt != '0) begin
                state     <= ST_AW;
                o_awvalid <= 1'b1;
                o_awaddr  <= burst_addr;
                o_awlen   <= 8'(beat_cnt) - 8'd1;
              end else begin
                state        <= ST_DONE;
                o_init_done  <= 1'b1;
                o_init_error <= 1'b1;
              end
            end else if (beat_close) begin
              beat_cnt  <= beat_cnt + 1'b1;
              image_end <= i_last;
              if (i_last || (beat_cnt == LAST_CNT)) begin
                // beat_cnt still holds the pre-close count, which is exactly beats-1
                state     <= ST_AW;
                o_ready   <= 1'b0;
                o_awvalid <= 1'b1;
                o_awaddr  <= burst_addr;
                o_awlen   <= 8'(beat_cnt);
              end
            end
          end
        end
        ST_AW: begin
          if (i_awready) begin
            state     <= ST_W;
            o_awvalid <= 1'b0;
            o_wvalid  <= 1'b1;
            o_wdata   <= buf_data[0];
            o_wstrb   <= buf_strb[0];
            o_wlast   <= (o_awlen == 8'd0);
            w_idx     <= '0;
          end
        end
        ST_W: begin
          if (i_wready) begin
            if (o_wlast) begin
              state    <= ST_B;
              o_wvalid <= 1'b0;
              o_wlast  <= 1'b0;
              o_bready <= 1'b1;
            end else begin
              w_idx   <= w_next;
              o_wdata <= buf_data[w_next];
              o_wstrb <= buf_strb[w_next];
              o_wlast <= (8'(w_next) == o_awlen);
            end
          end
        end
        ST_B: begin
          if (i_bvalid) begin
            o_bready <= 1'b0;
            if (i_bresp != RESP_OKAY) begin
              state        <= ST_DONE;
              o_init_done  <= 1'b1;
              o_init_error <= 1'b1;
            end else begin
              beats_written <= beats_written + 32'(beat_cnt);
              beat_cnt      <= '0;
              if (image_end || overflow) begin
                state       <= ST_DONE;
                o_init_done <= 1'b1;
                if (overflow) begin
                  o_init_error <= 1'b1;
                end
              end else begin
                state   <= ST_FILL;
                o_ready <= 1'b1;
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
